// File: rtl/vector_sweep_sequencer_pkg.sv
// Shared types and constants for the vector sweep sequencer.
// Sweeps every DUT input vector in order and streams (vector, response) records.
package sweep_pkg;

  localparam int SETTLE_W = 8;
  localparam int MAX_N_IN = 16;

  // Prefixed literals so a SETTLE parameter can coexist with the state name.
  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_EMIT,
    ST_DONE
  } sweep_state_e;

  // The timer reaches zero after load_val further edges, so load one less than SETTLE.
  function automatic logic [SETTLE_W-1:0] settle_reload(input int settle);
    return SETTLE_W'(settle - 1);
  endfunction

endpackage

// File: rtl/vector_sweep_sequencer_if.sv
// Record stream between the sweep sequencer (master) and its log/compare sink (slave).
interface vector_sweep_sequencer_if #(
  parameter int N_IN  = 2,
  parameter int N_OUT = 1
) ();

  logic             rec_valid;
  logic             rec_ready;
  logic [N_IN-1:0]  rec_vec;
  logic [N_OUT-1:0] rec_resp;
  logic             rec_last;

  modport master (
    output rec_valid,
    output rec_vec,
    output rec_resp,
    output rec_last,
    input  rec_ready
  );

  modport slave (
    input  rec_valid,
    input  rec_vec,
    input  rec_resp,
    input  rec_last,
    output rec_ready
  );

endinterface

// File: rtl/vector_sweep_sequencer_settle_timer.sv
// Loadable down-counter; zero is high once the loaded count has run out.
module sweep_settle_timer
  import sweep_pkg::*;
(
  input  logic                CK,
  input  logic                reset,
  input  logic                load,
  input  logic [SETTLE_W-1:0] load_val,
  output logic                zero
);

  logic [SETTLE_W-1:0] cnt;

  always_ff @(posedge CK) begin
    if (reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - SETTLE_W'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/vector_sweep_sequencer.sv
// Drives 0 .. 2^N_IN-1 into a benchmark DUT, waits SETTLE cycles per vector,
// captures dut_out and hands each (vector, response) record to the sink.
//
//  state     | meaning
//  ----------+---------------------------------------------------------
//  ST_IDLE   | no sweep; waiting for start
//  ST_SETTLE | vector on dut_in, counting down until dut_out is sampled
//  ST_EMIT   | record presented on rec, waiting for the sink to accept
//  ST_DONE   | last record accepted; done pulses for this one cycle
module vector_sweep_sequencer
  import sweep_pkg::*;
#(
  parameter int N_IN   = 2,
  parameter int N_OUT  = 1,
  parameter int SETTLE = 1
) (
  input  logic                    CK,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    abort,
  output logic [N_IN-1:0]         dut_in,
  input  logic [N_OUT-1:0]        dut_out,
  vector_sweep_sequencer_if.master rec,
  output logic                    busy,
  output logic                    done,
  output logic [N_IN:0]           vec_count
);

  localparam logic [SETTLE_W-1:0] RELOAD = settle_reload(SETTLE);

  sweep_state_e     state_q, state_d;
  logic [N_IN-1:0]  dut_in_q, dut_in_d;
  logic [N_IN-1:0]  rec_vec_q, rec_vec_d;
  logic [N_OUT-1:0] rec_resp_q, rec_resp_d;
  logic             rec_last_q, rec_last_d;
  logic             rec_valid_q, rec_valid_d;
  logic [N_IN:0]    vec_count_q, vec_count_d;
  logic             timer_load;
  logic             timer_zero;

  sweep_settle_timer u_settle_timer (
    .CK       (CK),
    .reset    (reset),
    .load     (timer_load),
    .load_val (RELOAD),
    .zero     (timer_zero)
  );

  always_ff @(posedge CK) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      dut_in_q    <= '0;
      rec_vec_q   <= '0;
      rec_resp_q  <= '0;
      rec_last_q  <= 1'b0;
      rec_valid_q <= 1'b0;
      vec_count_q <= '0;
    end else begin
      state_q     <= state_d;
      dut_in_q    <= dut_in_d;
      rec_vec_q   <= rec_vec_d;
      rec_resp_q  <= rec_resp_d;
      rec_last_q  <= rec_last_d;
      rec_valid_q <= rec_valid_d;
      vec_count_q <= vec_count_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    dut_in_d    = dut_in_q;
    rec_vec_d   = rec_vec_q;
    rec_resp_d  = rec_resp_q;
    rec_last_d  = rec_last_q;
    rec_valid_d = rec_valid_q;
    vec_count_d = vec_count_q;
    timer_load  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start && !abort) begin
          dut_in_d    = '0;
          vec_count_d = '0;
          timer_load  = 1'b1;
          state_d     = ST_SETTLE;
        end
      end

      ST_SETTLE: begin
        if (abort) begin
          rec_valid_d = 1'b0;
          dut_in_d    = '0;
          state_d     = ST_IDLE;
        end else if (timer_zero) begin
          rec_resp_d  = dut_out;
          rec_vec_d   = dut_in_q;
          rec_last_d  = (dut_in_q == '1);
          rec_valid_d = 1'b1;
          state_d     = ST_EMIT;
        end
      end

      ST_EMIT: begin
        // abort beats a coincident handshake, so that record is never counted
        if (abort) begin
          rec_valid_d = 1'b0;
          dut_in_d    = '0;
          state_d     = ST_IDLE;
        end else if (rec.rec_ready) begin
          rec_valid_d = 1'b0;
          vec_count_d = vec_count_q + (N_IN+1)'(1);
          if (rec_last_q) begin
            state_d = ST_DONE;
          end else begin
            dut_in_d   = dut_in_q + N_IN'(1);
            timer_load = 1'b1;
            state_d    = ST_SETTLE;
          end
        end
      end

      ST_DONE: begin
        dut_in_d = '0;
        state_d  = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign dut_in        = dut_in_q;
  assign rec.rec_valid = rec_valid_q;
  assign rec.rec_vec   = rec_vec_q;
  assign rec.rec_resp  = rec_resp_q;
  assign rec.rec_last  = rec_last_q;
  assign busy          = (state_q != ST_IDLE);
  assign done          = (state_q == ST_DONE);
  assign vec_count     = vec_count_q;

endmodule

// File: tb/tb_vector_sweep_sequencer.sv
// Bench for vector_sweep_sequencer: a SETTLE=1 instance checked every cycle against a
// record-level model, plus a SETTLE=3 instance fed by a two-cycle-latency DUT model.
module tb_vector_sweep_sequencer;

  localparam int N_IN  = 2;
  localparam int N_OUT = 1;
  localparam int S1    = 1;
  localparam int S3    = 3;
  localparam int LASTV = (1 << N_IN) - 1;

  logic CK = 1'b0;
  always #5 CK = ~CK;

  logic reset = 1'b1;

  // SETTLE=1 instance, combinational parity DUT
  logic             start = 1'b0, abort = 1'b0, ready = 1'b0;
  logic [N_IN-1:0]  dut_in;
  logic [N_OUT-1:0] dut_out;
  logic             busy, done;
  logic [N_IN:0]    vec_count;
  vector_sweep_sequencer_if #(.N_IN(N_IN), .N_OUT(N_OUT)) rec_if ();
  assign rec_if.rec_ready = ready;
  assign dut_out = ^dut_in;

  vector_sweep_sequencer #(.N_IN(N_IN), .N_OUT(N_OUT), .SETTLE(S1)) u_dut (
    .CK(CK), .reset(reset), .start(start), .abort(abort),
    .dut_in(dut_in), .dut_out(dut_out), .rec(rec_if.master),
    .busy(busy), .done(done), .vec_count(vec_count)
  );

  // SETTLE=3 instance, parity DUT registered twice
  logic             start3 = 1'b0, abort3 = 1'b0, ready3 = 1'b0;
  logic [N_IN-1:0]  dut_in3;
  logic [N_OUT-1:0] dut_out3;
  logic             busy3, done3;
  logic [N_IN:0]    vec_count3;
  logic             d1, d2;
  vector_sweep_sequencer_if #(.N_IN(N_IN), .N_OUT(N_OUT)) rec3_if ();
  assign rec3_if.rec_ready = ready3;
  always @(posedge CK) begin
    d1 <= ^dut_in3;
    d2 <= d1;
  end
  assign dut_out3 = d2;

  vector_sweep_sequencer #(.N_IN(N_IN), .N_OUT(N_OUT), .SETTLE(S3)) u_dut3 (
    .CK(CK), .reset(reset), .start(start3), .abort(abort3),
    .dut_in(dut_in3), .dut_out(dut_out3), .rec(rec3_if.master),
    .busy(busy3), .done(done3), .vec_count(vec_count3)
  );

  int checks   = 0;
  int failures = 0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endfunction

  // Record-level model: phase 0 idle, 1 waiting for a record, 2 record offered, 3 done cycle
  int       m_phase = 0, m_vec = 0, m_wait = 0, m_count = 0;
  bit       m_valid = 0, m_resp = 0, m_last = 0;
  int       m_rvec = 0;

  always @(posedge CK) begin
    if (reset) begin
      m_phase = 0; m_vec = 0; m_wait = 0; m_count = 0;
      m_valid = 0; m_resp = 0; m_last = 0; m_rvec = 0;
    end else begin
      case (m_phase)
        0: if (start && !abort) begin
             m_vec = 0; m_count = 0; m_wait = S1; m_phase = 1;
           end
        1: if (abort) begin
             m_phase = 0; m_vec = 0;
           end else begin
             m_wait--;
             if (m_wait == 0) begin
               m_valid = 1; m_rvec = m_vec;
               m_resp  = ($countones(m_vec) % 2) == 1;
               m_last  = (m_vec == LASTV);
               m_phase = 2;
             end
           end
        2: if (abort) begin
             m_phase = 0; m_valid = 0; m_vec = 0;
           end else if (ready) begin
             m_valid = 0; m_count++;
             if (m_last) m_phase = 3;
             else begin
               m_vec++; m_wait = S1; m_phase = 1;
             end
           end
        default: begin
          m_vec = 0; m_phase = 0;
        end
      endcase
    end
  end

  bit cmp_en = 0;
  always @(negedge CK) begin
    if (cmp_en) begin
      chk("dut_in",    32'(dut_in),           32'(m_vec));
      chk("rec_valid", 32'(rec_if.rec_valid), 32'(m_valid));
      chk("rec_vec",   32'(rec_if.rec_vec),   32'(m_rvec));
      chk("rec_resp",  32'(rec_if.rec_resp),  32'(m_resp));
      chk("rec_last",  32'(rec_if.rec_last),  32'(m_last));
      chk("busy",      32'(busy),             32'(m_phase != 0));
      chk("done",      32'(done),             32'(m_phase == 3));
      chk("vec_count", 32'(vec_count),        32'(m_count));
    end
  end

  // Accepted-record logs and done-pulse bookkeeping
  int         cyc = 0, hs_cyc = 0, done_cyc = 0, done_cnt = 0;
  logic [3:0] recs[$];
  logic [3:0] recs3[$];
  always @(posedge CK) cyc++;
  always @(negedge CK) begin
    if (rec_if.rec_valid && ready && !abort) begin
      recs.push_back({rec_if.rec_vec, rec_if.rec_resp, rec_if.rec_last});
      hs_cyc = cyc;
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (rec3_if.rec_valid && ready3)
      recs3.push_back({rec3_if.rec_vec, rec3_if.rec_resp, rec3_if.rec_last});
  end

  // {vec, resp, last} expected for a full parity sweep
  logic [3:0] exp_rec [4] = '{4'b0000, 4'b0110, 4'b1010, 4'b1101};

  task automatic step();
    @(posedge CK);
    #1;
  endtask

  task automatic wait_done(input int max);
    int n = 0;
    while (done !== 1'b1 && n < max) begin
      step();
      n++;
    end
    chk("wait_done", 32'(done), 32'd1);
  endtask

  task automatic wait_valid(input int vec, input int max);
    int n = 0;
    while (!(rec_if.rec_valid === 1'b1 && rec_if.rec_vec == vec) && n < max) begin
      step();
      n++;
    end
    chk("wait_valid", 32'(rec_if.rec_valid), 32'd1);
  endtask

  task automatic check_recs(input string tag, input logic [3:0] q[$]);
    chk({tag, "_nrec"}, 32'(q.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < q.size()) chk({tag, "_rec"}, 32'(q[i]), 32'(exp_rec[i]));
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    // reset values
    reset = 1'b1;
    step();
    cmp_en = 1;
    step();
    chk("rst_dut_in", 32'(dut_in), 32'd0);
    chk("rst_valid",  32'(rec_if.rec_valid), 32'd0);
    chk("rst_busy",   32'(busy), 32'd0);
    chk("rst_done",   32'(done), 32'd0);
    chk("rst_count",  32'(vec_count), 32'd0);
    chk("rst_last",   32'(rec_if.rec_last), 32'd0);
    reset = 1'b0;
    step();

    // 1: free-flowing sweep
    recs.delete(); done_cnt = 0;
    ready = 1'b1;
    pulse_start();
    wait_done(40);
    step();
    check_recs("t1", recs);
    chk("t1_done_after_hs", 32'(done_cyc - hs_cyc), 32'd1);
    chk("t1_count",  32'(vec_count), 32'd4);
    chk("t1_dut_in", 32'(dut_in), 32'd0);
    chk("t1_ndone",  32'(done_cnt), 32'd1);

    // 2: backpressure on record 01
    recs.delete(); done_cnt = 0;
    ready = 1'b0;
    pulse_start();
    wait_valid(0, 20);
    ready = 1'b1;
    step();
    ready = 1'b0;
    wait_valid(1, 20);
    for (int k = 0; k < 3; k++) begin
      chk("t2_hold_vec",   32'(rec_if.rec_vec), 32'd1);
      chk("t2_hold_resp",  32'(rec_if.rec_resp), 32'd1);
      chk("t2_hold_din",   32'(dut_in), 32'd1);
      chk("t2_hold_valid", 32'(rec_if.rec_valid), 32'd1);
      step();
    end
    ready = 1'b1;
    wait_done(40);
    step();
    check_recs("t2", recs);
    chk("t2_count", 32'(vec_count), 32'd4);

    // 3: SETTLE=3 with a two-cycle-latency DUT
    recs3.delete();
    ready3 = 1'b0;
    start3 = 1'b1;
    step();
    start3 = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      step();
      chk("t3_first_valid", 32'(rec3_if.rec_valid), 32'(k == 3));
    end
    ready3 = 1'b1;
    for (int n = 0; n < 60 && done3 !== 1'b1; n++) step();
    chk("t3_done", 32'(done3), 32'd1);
    step();
    check_recs("t3", recs3);
    chk("t3_count", 32'(vec_count3), 32'd4);
    ready3 = 1'b0;

    // 4: abort coincident with a handshake on record 10
    recs.delete(); done_cnt = 0;
    ready = 1'b1;
    pulse_start();
    wait_valid(2, 20);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("t4_busy",  32'(busy), 32'd0);
    chk("t4_valid", 32'(rec_if.rec_valid), 32'd0);
    chk("t4_count", 32'(vec_count), 32'd2);
    chk("t4_din",   32'(dut_in), 32'd0);
    step();
    step();
    chk("t4_ndone", 32'(done_cnt), 32'd0);
    chk("t4_nrec",  32'(recs.size()), 32'd2);

    // 5: reset while settling record 01, then a fresh sweep
    recs.delete();
    pulse_start();
    wait_valid(0, 20);
    step();
    chk("t5_pre_din",  32'(dut_in), 32'd1);
    chk("t5_pre_busy", 32'(busy), 32'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("t5_rst_din",   32'(dut_in), 32'd0);
    chk("t5_rst_busy",  32'(busy), 32'd0);
    chk("t5_rst_valid", 32'(rec_if.rec_valid), 32'd0);
    chk("t5_rst_vec",   32'(rec_if.rec_vec), 32'd0);
    chk("t5_rst_count", 32'(vec_count), 32'd0);
    recs.delete(); done_cnt = 0;
    pulse_start();
    wait_done(40);
    step();
    check_recs("t5", recs);
    chk("t5_count", 32'(vec_count), 32'd4);

    // 6: start re-pulsed while busy
    recs.delete(); done_cnt = 0;
    pulse_start();
    for (int k = 0; k < 3; k++) begin
      step();
      pulse_start();
    end
    wait_done(40);
    repeat (5) step();
    check_recs("t6", recs);
    chk("t6_ndone", 32'(done_cnt), 32'd1);
    chk("t6_busy",  32'(busy), 32'd0);
    chk("t6_count", 32'(vec_count), 32'd4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
